// File: rtl/lut_mult_loader_pkg.sv
// Shared definitions for the run-time loadable product table.
//   - default widths for the table address, coefficient and data word
//   - FSM state type used by the loader
//   - reference product function (addr * coef) for checking environments
package lut_mult_loader_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_COEF_W = 8;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Product that the table word at 'addr' must hold after a load of 'coef'.
    function automatic logic [DEF_DATA_W-1:0] ref_product(
        input logic [DEF_ADDR_W-1:0] addr,
        input logic [DEF_COEF_W-1:0] coef
    );
        logic [DEF_DATA_W-1:0] a_ext;
        logic [DEF_DATA_W-1:0] c_ext;
        a_ext = DEF_DATA_W'(addr);
        c_ext = DEF_DATA_W'(coef);
        return a_ext * c_ext;
    endfunction

endpackage

// File: rtl/lut_ram_1w1r.sv
// Simple 2**ADDR_W x DATA_W storage array.
//   clk   : write clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : mem[raddr]
// No reset: contents persist across reset and are undefined after power-up.
module lut_ram_1w1r #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lut_mult_loader.sv
// Loadable coefficient-product table for the distributed-arithmetic FIR.
// On an accepted start the table is filled with addr*coef for every address,
// built by repeated addition (no multiplier), then read like a product ROM.
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   start       : load request, honoured only in IDLE
//   coef        : unsigned coefficient, captured on accepted start
//   busy        : high while the table is being filled
//   done        : one-cycle pulse when the fill completes
//   table_valid : table holds a complete product set
//   rd_addr     : read address from the FIR datapath
//   rd_data     : combinational read of the table at rd_addr
// DATA_W must be at least ADDR_W+COEF_W for the products to be exact.
module lut_mult_loader
    import lut_mult_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [COEF_W-1:0] coef,
    output logic              busy,
    output logic              done,
    output logic              table_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_nxt;
    logic [COEF_W-1:0] coef_q;
    logic [COEF_W-1:0] coef_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              table_valid_nxt;
    logic              wr_en;
    logic              last_addr;

    assign last_addr = (wr_addr == {ADDR_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_addr     <= '0;
            acc         <= '0;
            coef_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            table_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_addr     <= wr_addr_nxt;
            acc         <= acc_nxt;
            coef_q      <= coef_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            table_valid <= table_valid_nxt;
        end
    end

    // Status outputs are registered: they change on the edge that leaves a
    // state, so busy covers FILL and DONE, and done/table_valid appear on the
    // edge that returns to IDLE.
    always_comb begin
        state_nxt       = state;
        wr_addr_nxt     = wr_addr;
        acc_nxt         = acc;
        coef_nxt        = coef_q;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        table_valid_nxt = table_valid;
        wr_en           = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    coef_nxt        = coef;
                    acc_nxt         = '0;
                    wr_addr_nxt     = '0;
                    table_valid_nxt = 1'b0;
                    busy_nxt        = 1'b1;
                    state_nxt       = FILL;
                end
            end
            FILL: begin
                wr_en       = 1'b1;
                acc_nxt     = acc + DATA_W'(coef_q);
                // Wrap to 0 after the last address is harmless.
                wr_addr_nxt = wr_addr + ADDR_W'(1);
                if (last_addr) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_nxt        = 1'b1;
                busy_nxt        = 1'b0;
                table_valid_nxt = 1'b1;
                state_nxt       = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    lut_ram_1w1r #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (acc),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_lut_mult_loader.sv
// Self-checking bench for lut_mult_loader: timing of busy/done/table_valid,
// ignored starts, reloads, async reset mid-fill, and full table contents
// checked through an expected-value queue.
module tb_lut_mult_loader;
    import lut_mult_loader_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  coef;
    logic        busy;
    logic        done;
    logic        table_valid;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;

    int n_vec;
    int n_err;
    logic [31:0] exp_q[$];

    lut_mult_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .coef        (coef),
        .busy        (busy),
        .done        (done),
        .table_valid (table_valid),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive start for one sampling edge; returns #1 after that edge.
    task automatic pulse_start(input logic [7:0] c);
        @(negedge clk);
        coef  = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("valid_at_done", 32'(table_valid), 32'd1);
    endtask

    task automatic load(input logic [7:0] c);
        pulse_start(c);
        check_eq("busy_on_accept", 32'(busy), 32'd1);
        check_eq("valid_drop_on_accept", 32'(table_valid), 32'd0);
        wait_done();
    endtask

    task automatic read_one(input logic [7:0] a, input logic [7:0] c, input string tag);
        logic [31:0] e;
        @(negedge clk);
        rd_addr = a;
        exp_q.push_back(32'(ref_product(a, c)));
        #1;
        e = exp_q.pop_front();
        check_eq(tag, 32'(rd_data), e);
    endtask

    task automatic sweep(input logic [7:0] c);
        for (int a = 0; a < 256; a++) begin
            read_one(8'(a), c, "rd_sweep");
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        coef    = 8'd0;
        rd_addr = 8'd0;
        #12;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_valid", 32'(table_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Timing run with coef=2, stray start (coef=9) sampled at edge 100.
        pulse_start(8'd2);
        check_eq("t0_busy", 32'(busy), 32'd1);
        check_eq("t0_done", 32'(done), 32'd0);
        for (int k = 1; k <= 260; k++) begin
            @(posedge clk);
            #1;
            if (k == 99) begin
                start = 1'b1;
                coef  = 8'd9;
            end
            if (k == 100) begin
                start = 1'b0;
                coef  = 8'd0;
            end
            check_eq("t_busy", 32'(busy), 32'(k <= 256));
            check_eq("t_done", 32'(done), 32'(k == 257));
            check_eq("t_valid", 32'(table_valid), 32'(k >= 257));
        end
        read_one(8'd0, 8'd2, "c2_a0");
        read_one(8'd1, 8'd2, "c2_a1");
        read_one(8'd127, 8'd2, "c2_a127");
        read_one(8'd128, 8'd2, "c2_a128");
        read_one(8'd255, 8'd2, "c2_a255");
        @(negedge clk);
        rd_addr = 8'd255;
        #1;
        check_eq("c2_a255_const", 32'(rd_data), 32'd510);
        sweep(8'd2);

        // Largest coefficient.
        load(8'd255);
        @(negedge clk);
        rd_addr = 8'd255;
        #1;
        check_eq("c255_a255_const", 32'(rd_data), 32'd65025);
        sweep(8'd255);

        // Reload with coef=3 then coef=0.
        load(8'd3);
        sweep(8'd3);
        load(8'd0);
        sweep(8'd0);

        // Async reset part way through a coef=5 fill.
        pulse_start(8'd5);
        for (int k = 1; k < 50; k++) begin
            @(posedge clk);
        end
        #3;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        check_eq("mid_rst_valid", 32'(table_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        load(8'd7);
        sweep(8'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
